// File: rtl/adc_sample_averager.sv
// 8-channel ADC block averager: 2^avg_log2 samples per window through one shared adder (offset port under ADC_AVG_OFFSET_EN).
// Latency: sample edge seen at clock edge T -> out_valid pulse after clock edge T+10 for the last sample of a window.
// No backpressure: a sample edge arriving while busy is dropped and flagged in the sticky overrun bit.
module adc_sample_averager #(
    parameter int AVG_LOG2_MAX = 4,
    parameter int ACC_W        = 15 + AVG_LOG2_MAX
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic [2:0]   avg_log2,
    input  logic         data_valid,
    input  logic [14:0]  data1,
    input  logic [14:0]  data2,
    input  logic [14:0]  data3,
    input  logic [14:0]  data4,
    input  logic [14:0]  data5,
    input  logic [14:0]  data6,
    input  logic [14:0]  data7,
    input  logic [14:0]  data8,
    input  logic         clear_overrun,
`ifdef ADC_AVG_OFFSET_EN
    input  logic [127:0] offset_flat,
`endif
    output logic         out_valid,
    output logic [15:0]  out1,
    output logic [15:0]  out2,
    output logic [15:0]  out3,
    output logic [15:0]  out4,
    output logic [15:0]  out5,
    output logic [15:0]  out6,
    output logic [15:0]  out7,
    output logic [15:0]  out8,
    output logic [15:0]  out_seq,
    output logic         overrun
);
    localparam int CNT_W = AVG_LOG2_MAX + 1;
    localparam logic [2:0] WIN_MAX = 3'(AVG_LOG2_MAX);
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(32767);
    localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-32768);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_ACCUM, S_EMIT} state_t;
    state_t r_state, w_state_nxt;

    logic                    r_dv_q;
    logic                    w_edge;
    logic [14:0]             w_data  [8];
    logic [14:0]             r_cap   [8];
    logic signed [ACC_W-1:0] r_acc   [8];
    logic signed [ACC_W-1:0] w_shift [8];
    logic signed [ACC_W:0]   w_diff  [8];
    logic [15:0]             w_off   [8];
    logic [15:0]             w_res   [8];
    logic [15:0]             r_out   [8];
    logic [ACC_W-1:0]        w_add;
    logic [2:0]              r_ch;
    logic [2:0]              r_win_log2;
    logic [2:0]              w_win_sel;
    logic [CNT_W-1:0]        r_sample_cnt;
    logic [CNT_W-1:0]        w_cnt_inc;
    logic [CNT_W-1:0]        w_win_len;
    logic                    w_win_done;
    logic                    r_out_valid;
    logic [15:0]             r_out_seq;
    logic                    r_overrun;

    assign w_data[0] = data1;
    assign w_data[1] = data2;
    assign w_data[2] = data3;
    assign w_data[3] = data4;
    assign w_data[4] = data5;
    assign w_data[5] = data6;
    assign w_data[6] = data7;
    assign w_data[7] = data8;

    assign w_edge     = data_valid & ~r_dv_q;
    assign w_win_sel  = (avg_log2 > WIN_MAX) ? WIN_MAX : avg_log2;
    assign w_cnt_inc  = r_sample_cnt + CNT_W'(1);
    assign w_win_len  = CNT_W'(1) << r_win_log2;
    assign w_win_done = (w_cnt_inc == w_win_len);
    assign w_add      = {{(ACC_W-15){r_cap[r_ch][14]}}, r_cap[r_ch]};

    always_comb begin
        for (int k = 0; k < 8; k++) begin
`ifdef ADC_AVG_OFFSET_EN
            w_off[k] = offset_flat[16*k +: 16];
`else
            w_off[k] = 16'h0000;
`endif
        end
    end

    // Average, subtract offset and clamp; in-range values pass through unchanged.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_shift[k] = r_acc[k] >>> r_win_log2;
            w_diff[k]  = {w_shift[k][ACC_W-1], w_shift[k]} - {{(ACC_W-15){w_off[k][15]}}, w_off[k]};
            if (w_diff[k] > SAT_MAX)
                w_res[k] = 16'h7FFF;
            else if (w_diff[k] < SAT_MIN)
                w_res[k] = 16'h8000;
            else
                w_res[k] = w_diff[k][15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (w_edge) w_state_nxt = S_CAPTURE;
                S_CAPTURE: w_state_nxt = S_ACCUM;
                S_ACCUM:   if (r_ch == 3'd7) w_state_nxt = w_win_done ? S_EMIT : S_IDLE;
                S_EMIT:    w_state_nxt = S_IDLE;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Starts high so a data_valid already asserted out of reset is not taken as an edge.
            r_dv_q       <= 1'b1;
            r_ch         <= '0;
            r_win_log2   <= '0;
            r_sample_cnt <= '0;
            r_out_valid  <= 1'b0;
            r_out_seq    <= '0;
            r_overrun    <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                r_cap[k] <= '0;
                r_acc[k] <= '0;
                r_out[k] <= '0;
            end
        end else begin
            r_dv_q      <= data_valid;
            r_out_valid <= 1'b0;
            if (enable && w_edge && (r_state != S_IDLE))
                r_overrun <= 1'b1;
            else if (clear_overrun)
                r_overrun <= 1'b0;

            if (!enable) begin
                r_ch         <= '0;
                r_sample_cnt <= '0;
                for (int k = 0; k < 8; k++) r_acc[k] <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_edge && (r_sample_cnt == '0)) r_win_log2 <= w_win_sel;
                    end
                    S_CAPTURE: begin
                        r_ch <= '0;
                        for (int k = 0; k < 8; k++) r_cap[k] <= w_data[k];
                    end
                    S_ACCUM: begin
                        r_acc[r_ch] <= r_acc[r_ch] + w_add;
                        r_ch        <= r_ch + 3'd1;
                        if (r_ch == 3'd7) r_sample_cnt <= w_cnt_inc;
                    end
                    S_EMIT: begin
                        r_out_valid  <= 1'b1;
                        r_out_seq    <= r_out_seq + 16'd1;
                        r_sample_cnt <= '0;
                        for (int k = 0; k < 8; k++) begin
                            r_out[k] <= w_res[k];
                            r_acc[k] <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out1      = r_out[0];
    assign out2      = r_out[1];
    assign out3      = r_out[2];
    assign out4      = r_out[3];
    assign out5      = r_out[4];
    assign out6      = r_out[5];
    assign out7      = r_out[6];
    assign out8      = r_out[7];
    assign out_seq   = r_out_seq;
    assign overrun   = r_overrun;
endmodule
